// File: rtl/pipelined_shifter_pkg.sv
// Shared types for the pipelined shifter: operation encodings.
// The 000/001/010 codes match the legacy 2-bit shifter.
package shifter_pkg;

  typedef enum logic [2:0] {
    SH_SRL  = 3'b000,
    SH_SLL  = 3'b001,
    SH_SRA  = 3'b010,
    SH_PASS = 3'b011,
    SH_ROR  = 3'b100,
    SH_ROL  = 3'b101
  } sh_type_e;

endpackage

// File: rtl/pipelined_shifter_stage.sv
// One pipeline step: shift/rotate by 2^STAGE_K when en is set, else pass through.
// Rotates exist only when PIPELINED_SHIFTER_ROTATE_EN is defined.
module shifter_stage
  import shifter_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int STAGE_K = 0
) (
  input  logic [XLEN-1:0] din,
  input  logic            en,
  input  sh_type_e        typ,
  input  logic            sign,
  output logic [XLEN-1:0] dout
);

  localparam int AMT = 1 << STAGE_K;

  always_comb begin
    dout = din;
    if (en) begin
      case (typ)
        SH_SRL: dout = din >> AMT;
        SH_SLL: dout = din << AMT;
        SH_SRA: dout = {{AMT{sign}}, din[XLEN-1:AMT]};
`ifdef PIPELINED_SHIFTER_ROTATE_EN
        SH_ROR: dout = {din[AMT-1:0], din[XLEN-1:AMT]};
        SH_ROL: dout = {din[XLEN-AMT-1:0], din[XLEN-1:XLEN-AMT]};
`endif
        default: dout = din;
      endcase
    end
  end

endmodule

// File: rtl/pipelined_shifter.sv
// Pipelined barrel shifter, one shamt bit per stage, with valid/ready and tag.
// Define PIPELINED_SHIFTER_ROTATE_EN to enable ROR/ROL; otherwise they pass.
module pipelined_shifter
  import shifter_pkg::*;
#(
  parameter  int XLEN    = 32,
  parameter  int TAG_W   = 5,
  localparam int SHAMT_W = $clog2(XLEN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [XLEN-1:0]    in_a,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [2:0]         in_type,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_r,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int LAST = SHAMT_W - 1;

  // Payload width depends on XLEN/TAG_W, so the struct lives with the parameters.
  typedef struct packed {
    logic [XLEN-1:0]    data;
    logic [SHAMT_W-1:0] shamt;
    sh_type_e           typ;
    logic               sign;
    logic [TAG_W-1:0]   tag;
  } stage_t;

  stage_t          st  [SHAMT_W];
  logic            vld [SHAMT_W];
  logic [XLEN-1:0] res [SHAMT_W];
  logic            advance;

  assign advance   = !vld[LAST] || out_ready;
  assign in_ready  = advance;
  assign out_valid = vld[LAST];
  assign out_r     = st[LAST].data;
  assign out_tag   = st[LAST].tag;

  for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
    logic [XLEN-1:0] din;
    logic            en;
    sh_type_e        typ;
    logic            sign;

    // Stage 0 works directly on the request so S0 already holds the first step.
    if (k == 0) begin : g_first
      assign din  = in_a;
      assign en   = in_shamt[0];
      assign typ  = sh_type_e'(in_type);
      assign sign = in_a[XLEN-1];
    end else begin : g_rest
      assign din  = st[k-1].data;
      assign en   = st[k-1].shamt[k];
      assign typ  = st[k-1].typ;
      assign sign = st[k-1].sign;
    end

    shifter_stage #(
      .XLEN    (XLEN),
      .STAGE_K (k)
    ) u_stage (
      .din  (din),
      .en   (en),
      .typ  (typ),
      .sign (sign),
      .dout (res[k])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < SHAMT_W; k++) begin
        vld[k] <= 1'b0;
        st[k]  <= '0;
      end
    end else if (flush) begin
      for (int unsigned k = 0; k < SHAMT_W; k++) vld[k] <= 1'b0;
    end else if (advance) begin
      vld[0] <= in_valid;
      st[0]  <= '{data: res[0], shamt: in_shamt, typ: sh_type_e'(in_type),
                  sign: in_a[XLEN-1], tag: in_tag};
      for (int unsigned k = 1; k < SHAMT_W; k++) begin
        vld[k] <= vld[k-1];
        st[k]  <= '{data: res[k], shamt: st[k-1].shamt, typ: st[k-1].typ,
                    sign: st[k-1].sign, tag: st[k-1].tag};
      end
    end
  end

endmodule

// File: tb/tb_pipelined_shifter.sv
// Randomized and directed bench for pipelined_shifter (XLEN=32) against a slot/queue model.
// Honors PIPELINED_SHIFTER_ROTATE_EN the same way the design does.
module tb_pipelined_shifter;

  localparam int XLEN = 32;
  localparam int TAG_W = 5;
  localparam int DEPTH = 5;

  logic             clk = 1'b0;
  logic             rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [XLEN-1:0]  in_a, out_r;
  logic [4:0]       in_shamt;
  logic [2:0]       in_type;
  logic [TAG_W-1:0] in_tag, out_tag;

  pipelined_shifter #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_shamt  (in_shamt),
    .in_type   (in_type),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_r     (out_r),
    .out_tag   (out_tag)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned n_ret    = 0;
  int unsigned n_seen   = 0;
  bit          armed    = 1'b0;

  // Model: one slot per pipeline position holding the final result, plus issue-order queues.
  logic             m_v [DEPTH];
  logic [XLEN-1:0]  m_r [DEPTH];
  logic [TAG_W-1:0] m_t [DEPTH];
  logic [XLEN-1:0]  q_r [$];
  logic [TAG_W-1:0] q_t [$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [XLEN-1:0] ref_op(input logic [XLEN-1:0] a, input logic [4:0] sh,
                                              input logic [2:0] ty);
    logic [2*XLEN-1:0] aa;
    aa = {a, a};
    case (ty)
      3'b000: return a >> sh;
      3'b001: return a << sh;
      3'b010: return XLEN'($signed(a) >>> sh);
`ifdef PIPELINED_SHIFTER_ROTATE_EN
      3'b100: begin aa = aa >> sh; return aa[XLEN-1:0]; end
      3'b101: begin aa = aa << sh; return aa[2*XLEN-1:XLEN]; end
`endif
      default: return a;
    endcase
  endfunction

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) begin
      m_v[i] = 1'b0; m_r[i] = '0; m_t[i] = '0;
    end
    q_r.delete(); q_t.delete();
  endtask

  task automatic step(input logic iv, input logic [XLEN-1:0] a, input logic [4:0] sh,
                      input logic [2:0] ty, input logic [TAG_W-1:0] tg, input logic ordy,
                      input logic fl, input logic rs);
    logic adv;
    @(negedge clk);
    in_valid = iv; in_a = a; in_shamt = sh; in_type = ty; in_tag = tg;
    out_ready = ordy; flush = fl; rst = rs;
    #1;
    adv = !m_v[DEPTH-1] || ordy;
    if (armed) begin
      check_eq("out_valid", out_valid, m_v[DEPTH-1]);
      check_eq("in_ready", in_ready, adv);
      if (m_v[DEPTH-1]) begin
        check_eq("out_r", out_r, m_r[DEPTH-1]);
        check_eq("out_tag", out_tag, m_t[DEPTH-1]);
        if (ordy) begin
          check_eq("sb_nonempty", q_r.size() != 0, 1);
          if (q_r.size() != 0) begin
            check_eq("sb_r", out_r, q_r[0]);
            check_eq("sb_tag", out_tag, q_t[0]);
          end
        end
      end
    end
    if (out_valid === 1'b1) n_seen++;
    if (rs) clear_model();
    else if (fl) begin
      for (int i = 0; i < DEPTH; i++) m_v[i] = 1'b0;
      q_r.delete(); q_t.delete();
    end else if (adv) begin
      if (m_v[DEPTH-1]) begin
        n_ret++;
        if (q_r.size() != 0) begin void'(q_r.pop_front()); void'(q_t.pop_front()); end
      end
      for (int i = DEPTH-1; i > 0; i--) begin
        m_v[i] = m_v[i-1]; m_r[i] = m_r[i-1]; m_t[i] = m_t[i-1];
      end
      m_v[0] = iv; m_r[0] = ref_op(a, sh, ty); m_t[0] = tg;
      if (iv) begin q_r.push_back(ref_op(a, sh, ty)); q_t.push_back(tg); end
    end
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 3'b000, '0, 1'b1, 1'b0, 1'b0);
  endtask

  // Issue one op and wait (bounded) for it to appear; reports cycles from acceptance.
  task automatic issue_wait(input logic [XLEN-1:0] a, input logic [4:0] sh, input logic [2:0] ty,
                            input logic [TAG_W-1:0] tg, output int lat);
    step(1'b1, a, sh, ty, tg, 1'b1, 1'b0, 1'b0);
    lat = 1;
    #1;
    while (out_valid !== 1'b1 && lat < 20) begin
      step(1'b0, '0, '0, 3'b000, '0, 1'b1, 1'b0, 1'b0);
      #1;
      lat++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, ret0;
    logic [XLEN-1:0] rot_exp;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_a = '0; in_shamt = '0;
    in_type = '0; in_tag = '0; out_ready = 1'b1;
    clear_model();

    // Reset state.
    step(1'b0, '0, '0, 3'b000, '0, 1'b1, 1'b0, 1'b1);
    step(1'b0, '0, '0, 3'b000, '0, 1'b1, 1'b0, 1'b1);
    armed = 1'b1;
    #1;
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_r", out_r, 0);
    check_eq("rst_out_tag", out_tag, 0);
    check_eq("rst_in_ready", in_ready, 1);

    // SRA latency and sign fill.
    issue_wait(32'h8000_0000, 5'd4, 3'b010, 5'd7, lat);
    check_eq("sra_latency", lat, 5);
    check_eq("sra_r", out_r, 32'hF800_0000);
    check_eq("sra_tag", out_tag, 5'd7);
    idle(3);

    // Back-to-back SLL sweep.
    ret0 = n_ret;
    for (int k = 0; k < 32; k++) step(1'b1, 32'h1, 5'(k), 3'b001, 5'(k), 1'b1, 1'b0, 1'b0);
    idle(DEPTH);
    check_eq("sll_retired", n_ret - ret0, 32);

    // Stall with a full pipeline, inputs held pending.
    for (int i = 0; i < 7; i++)
      step(1'b1, $urandom, 5'($urandom), 3'($urandom), 5'(i), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      step(1'b1, $urandom, 5'($urandom), 3'($urandom), 5'(20 + i), 1'b0, 1'b0, 1'b0);
    #1;
    check_eq("stall_in_ready", in_ready, 0);
    idle(DEPTH + 2);

    // Flush with three ops in flight plus a same-cycle request.
    for (int i = 0; i < 3; i++) step(1'b1, 32'hA5A5_0000 + i, 5'd3, 3'b000, 5'(i), 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'h1234_5678, 5'd1, 3'b001, 5'd3, 1'b1, 1'b1, 1'b0);
    n_seen = 0;
    idle(DEPTH + 2);
    check_eq("flush_no_valid", n_seen, 0);
    issue_wait(32'h0000_00F0, 5'd4, 3'b000, 5'd11, lat);
    check_eq("post_flush_latency", lat, 5);
    check_eq("post_flush_r", out_r, 32'h0000_000F);
    idle(2);

    // Rotate (or pass in the default build).
`ifdef PIPELINED_SHIFTER_ROTATE_EN
    rot_exp = 32'h8000_0000;
`else
    rot_exp = 32'h0000_0001;
`endif
    issue_wait(32'h0000_0001, 5'd1, 3'b100, 5'd9, lat);
    check_eq("ror_r", out_r, rot_exp);
    check_eq("ror_tag", out_tag, 5'd9);
    idle(2);

    // Reset mid-stream.
    for (int i = 0; i < 4; i++) step(1'b1, $urandom, 5'($urandom), 3'($urandom), 5'(i), 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'hFFFF_FFFF, 5'd2, 3'b010, 5'd30, 1'b1, 1'b0, 1'b1);
    #1;
    check_eq("mid_rst_out_valid", out_valid, 0);
    check_eq("mid_rst_out_r", out_r, 0);
    check_eq("mid_rst_in_ready", in_ready, 1);
    n_seen = 0;
    idle(DEPTH + 2);
    check_eq("mid_rst_no_valid", n_seen, 0);

    // Randomized traffic with stalls, flushes and occasional reset.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 3) != 0), $urandom, 5'($urandom), 3'($urandom), 5'($urandom),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 39) == 0), ($urandom_range(0, 99) == 0));
    end
    idle(DEPTH + 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
